md4_core: RTL and testbench



---
 rtl/md4_core.sv | 116 +++++++++++
 tb/tb_md4_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md4_core.sv
// md4_core: MD4 compression engine with valid/ready handshake, several steps per clock and held output
module md4_core #(
  parameter int STEPS_PER_CYCLE = 1,
  parameter bit BYTESWAP = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  state_a,
  input  logic [31:0]  state_b,
  input  logic [31:0]  state_c,
  input  logic [31:0]  state_d,
  input  logic [511:0] data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  newstate_a,
  output logic [31:0]  newstate_b,
  output logic [31:0]  newstate_c,
  output logic [31:0]  newstate_d,
  output logic [5:0]   step
);
  localparam int S = STEPS_PER_CYCLE;
  localparam logic [2:0][3:0][4:0] SHT = {
    {5'd15, 5'd11, 5'd9, 5'd3},
    {5'd13, 5'd9, 5'd5, 5'd3},
    {5'd19, 5'd11, 5'd7, 5'd3}
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t state, state_n;
  logic [15:0][31:0] x_in, x_q;
  logic [31:0] aa, bb, cc, dd, sa, sb, sc, sd;
  logic [127:0] chain;
  logic accept, last;

  if (!(S == 1 || S == 2 || S == 3 || S == 4 || S == 6 || S == 8 || S == 12 || S == 16)) begin : g_bad_steps
    $error("md4_core: STEPS_PER_CYCLE must divide 48 (1,2,3,4,6,8,12,16)");
  end

  for (genvar i = 0; i < 16; i++) begin : g_word
    logic [31:0] w;
    assign w = data[511-32*i -: 32];
    assign x_in[i] = BYTESWAP ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  end

  // One MD4 step on {a,b,c,d}; the result is rotated to {d,a',b,c} so the next step always targets a
  function automatic logic [127:0] md4_step(input logic [127:0] st, input logic [5:0] k,
                                            input logic [15:0][31:0] x);
    logic [31:0] a, b, c, d, f, w, kc, t;
    logic [63:0] tt;
    logic [3:0] i;
    logic [1:0] r;
    {a, b, c, d} = st;
    i = k[3:0];
    r = k[5:4];
    f = r == 2'd0 ? (b & c) | (~b & d) : r == 2'd1 ? (b & c) | (b & d) | (c & d) : b ^ c ^ d;
    w = r == 2'd0 ? x[i] : r == 2'd1 ? x[{i[1:0], i[3:2]}] : x[{i[0], i[1], i[2], i[3]}];
    kc = r == 2'd0 ? 32'h0 : r == 2'd1 ? 32'h5A827999 : 32'h6ED9EBA1;
    t = a + f + w + kc;
    tt = {t, t} << SHT[r][i[1:0]];
    return {d, tt[63:32], b, c};
  endfunction

  assign accept = in_valid && in_ready;
  assign last = step == 6'd48;

  // Apply S consecutive steps starting at step as one combinational chain
  always_comb begin
    chain = {aa, bb, cc, dd};
    for (int j = 0; j < S; j++) chain = md4_step(chain, step + 6'(j), x_q);
  end

  // Next state: accept in IDLE, leave ROUND after step 48, leave DONE on the output handshake
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? ROUND : IDLE) :
              state == ROUND ? (last ? DONE : ROUND) :
              (out_ready ? IDLE : DONE);
  end

  // State register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= state_n;

  // Datapath: latch block, run rounds, feed-forward, registered handshake flags
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      step <= '0;
      x_q <= '0;
      {aa, bb, cc, dd} <= '0;
      {sa, sb, sc, sd} <= '0;
      {newstate_a, newstate_b, newstate_c, newstate_d} <= '0;
    end else begin
      in_ready <= state_n == IDLE;
      out_valid <= state_n == DONE;
      if (accept) begin
        x_q <= x_in;
        {aa, bb, cc, dd} <= {state_a, state_b, state_c, state_d};
        {sa, sb, sc, sd} <= {state_a, state_b, state_c, state_d};
        step <= '0;
      end else if (state == ROUND && !last) begin
        {aa, bb, cc, dd} <= chain;
        step <= step + 6'(S);
      end else if (state == ROUND) begin
        newstate_a <= sa + aa;
        newstate_b <= sb + bb;
        newstate_c <= sc + cc;
        newstate_d <= sd + dd;
      end
    end
endmodule

// File: tb/tb_md4_core.sv
// tb_md4_core: scoreboard bench for md4_core over every legal STEPS_PER_CYCLE
module tb_md4_core;
  localparam int NI = 8;
  localparam bit [NI-1:0][4:0] SVP = {5'd16, 5'd12, 5'd8, 5'd6, 5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [127:0] IV = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] E_EMPTY = 128'he0cfd631_31e96ad1_d7593cb7_c089c0e0;
  localparam logic [127:0] E_ABC = 128'h7a0148a4_52d821af_e80ac15f_9d72a67a;

  typedef struct packed {
    logic [127:0] ns;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic iv [NI];
  logic ir [NI];
  logic ov [NI];
  logic orr [NI];
  logic [31:0] s_a [NI];
  logic [31:0] s_b [NI];
  logic [31:0] s_c [NI];
  logic [31:0] s_d [NI];
  logic [31:0] n_a [NI];
  logic [31:0] n_b [NI];
  logic [31:0] n_c [NI];
  logic [31:0] n_d [NI];
  logic [511:0] dat [NI];
  logic [5:0] stp [NI];
  exp_t q [NI][$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [511:0] d_empty, d_abc;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] ns_of(input int g);
    return {n_a[g], n_b[g], n_c[g], n_d[g]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic pv = 1'b0;
    md4_core #(.STEPS_PER_CYCLE(int'(SVP[g])), .BYTESWAP(1'b1)) u_dut (
      .clk(clk), .nrst(nrst),
      .in_valid(iv[g]), .in_ready(ir[g]),
      .state_a(s_a[g]), .state_b(s_b[g]), .state_c(s_c[g]), .state_d(s_d[g]),
      .data(dat[g]),
      .out_valid(ov[g]), .out_ready(orr[g]),
      .newstate_a(n_a[g]), .newstate_b(n_b[g]), .newstate_c(n_c[g]), .newstate_d(n_d[g]),
      .step(stp[g])
    );
    // Monitor: each new result is compared with the oldest expectation for this instance
    always @(negedge clk) begin
      exp_t e;
      if (ov[g] && !pv) begin
        if (q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result S=%0d: got %h want none", SVP[g], ns_of(g));
        end else begin
          e = q[g].pop_front();
          chk($sformatf("result S=%0d", SVP[g]), ns_of(g), e.ns);
          chk($sformatf("latency S=%0d", SVP[g]), 128'(cyc), 128'(e.cyc));
        end
      end
      pv = ov[g];
    end
  end

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction
  function automatic logic [31:0] bs(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction
  function automatic logic [31:0] ff(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) | (~x & z);
  endfunction
  function automatic logic [31:0] gg(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction
  function automatic logic [31:0] hh(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return x ^ y ^ z;
  endfunction

  // Reference MD4 compression written in the textbook a,d,c,b form
  function automatic logic [127:0] md4_ref(input logic [127:0] st, input logic [511:0] m);
    logic [31:0] x [16];
    logic [31:0] a, b, c, dd;
    int o;
    for (int i = 0; i < 16; i++) x[i] = bs(m[511-32*i -: 32]);
    {a, b, c, dd} = st;
    for (int j = 0; j < 4; j++) begin
      a = rl(a + ff(b, c, dd) + x[4*j], 3);
      dd = rl(dd + ff(a, b, c) + x[4*j+1], 7);
      c = rl(c + ff(dd, a, b) + x[4*j+2], 11);
      b = rl(b + ff(c, dd, a) + x[4*j+3], 19);
    end
    for (int j = 0; j < 4; j++) begin
      a = rl(a + gg(b, c, dd) + x[j] + 32'h5a827999, 3);
      dd = rl(dd + gg(a, b, c) + x[j+4] + 32'h5a827999, 5);
      c = rl(c + gg(dd, a, b) + x[j+8] + 32'h5a827999, 9);
      b = rl(b + gg(c, dd, a) + x[j+12] + 32'h5a827999, 13);
    end
    for (int j = 0; j < 4; j++) begin
      o = j == 1 ? 2 : j == 2 ? 1 : j;
      a = rl(a + hh(b, c, dd) + x[o] + 32'h6ed9eba1, 3);
      dd = rl(dd + hh(a, b, c) + x[o+8] + 32'h6ed9eba1, 9);
      c = rl(c + hh(dd, a, b) + x[o+4] + 32'h6ed9eba1, 11);
      b = rl(b + hh(c, dd, a) + x[o+12] + 32'h6ed9eba1, 15);
    end
    return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + dd};
  endfunction

  // Offer one block at a negedge; push the expected result once it has been accepted
  task automatic send(input int g, input logic [511:0] d, input logic [127:0] st, input logic [127:0] e);
    int n = 0;
    exp_t x;
    while (!ir[g] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ir[g]) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout S=%0d: got 0 want 1", SVP[g]);
      return;
    end
    dat[g] = d;
    {s_a[g], s_b[g], s_c[g], s_d[g]} = st;
    iv[g] = 1'b1;
    @(negedge clk);
    iv[g] = 1'b0;
    x.ns = e;
    x.cyc = 32'(cyc + 48 / int'(SVP[g]) + 1);
    q[g].push_back(x);
  endtask

  task automatic drain(input int g);
    int n = 0;
    while (q[g].size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q[g].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout S=%0d: pending %0d want 0", SVP[g], q[g].size());
      q[g].delete();
    end
  endtask

  task automatic wait_ov(input int g);
    int n = 0;
    while (!ov[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_arrives", 128'(ov[g]), 128'(1));
    @(negedge clk);
  endtask

  task automatic run_random(input int g, input int cnt);
    logic [511:0] d;
    logic [127:0] st;
    for (int k = 0; k < cnt; k++) begin
      for (int w = 0; w < 16; w++) d[511-32*w -: 32] = $urandom;
      st = {$urandom, $urandom, $urandom, $urandom};
      send(g, d, st, md4_ref(st, d));
    end
    drain(g);
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0;
      orr[g] = 1'b1;
      dat[g] = '0;
      {s_a[g], s_b[g], s_c[g], s_d[g]} = '0;
    end
    d_empty = '0;
    d_empty[511:504] = 8'h80;
    d_abc = '0;
    d_abc[511:480] = 32'h61626380;
    d_abc[63:32] = 32'h18000000;
    #1 nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 128'(ir[0]), 128'(0));
    chk("reset_out_valid", 128'(ov[0]), 128'(0));
    chk("reset_step", 128'(stp[0]), 128'(0));
    chk("reset_newstate", ns_of(0), 128'(0));
    chk("reset_in_ready_s16", 128'(ir[7]), 128'(0));
    nrst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", 128'(ir[0]), 128'(1));
    send(0, d_empty, IV, E_EMPTY);
    drain(0);
    send(7, d_abc, IV, E_ABC);
    drain(7);
    orr[0] = 1'b0;
    send(0, d_empty, IV, E_EMPTY);
    wait_ov(0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(ov[0]), 128'(1));
      chk("hold_newstate", ns_of(0), E_EMPTY);
      chk("hold_in_ready", 128'(ir[0]), 128'(0));
    end
    orr[0] = 1'b1;
    @(negedge clk);
    orr[0] = 1'b0;
    chk("release_in_ready", 128'(ir[0]), 128'(1));
    chk("release_out_valid", 128'(ov[0]), 128'(0));
    chk("release_keeps_newstate", ns_of(0), E_EMPTY);
    orr[0] = 1'b1;
    send(0, d_empty, IV, E_EMPTY);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int w = 0; w < 16; w++) dat[0][511-32*w -: 32] = $urandom;
      {s_a[0], s_b[0], s_c[0], s_d[0]} = {$urandom, $urandom, $urandom, $urandom};
      iv[0] = ~iv[0];
    end
    iv[0] = 1'b0;
    drain(0);
    repeat (60) @(negedge clk);
    send(0, d_empty, IV, E_EMPTY);
    repeat (20) @(negedge clk);
    chk("step_at_e20", 128'(stp[0]), 128'(20));
    nrst = 1'b0;
    #1;
    q[0].delete();
    chk("midround_reset_out_valid", 128'(ov[0]), 128'(0));
    chk("midround_reset_step", 128'(stp[0]), 128'(0));
    @(negedge clk);
    nrst = 1'b1;
    chk("midround_in_ready_low", 128'(ir[0]), 128'(0));
    @(negedge clk);
    chk("midround_in_ready_high", 128'(ir[0]), 128'(1));
    send(0, d_empty, IV, E_EMPTY);
    drain(0);
    repeat (60) @(negedge clk);
    orr[0] = 1'b0;
    send(0, d_abc, IV, E_ABC);
    wait_ov(0);
    nrst = 1'b0;
    #1;
    chk("middone_reset_out_valid", 128'(ov[0]), 128'(0));
    chk("middone_reset_newstate", ns_of(0), 128'(0));
    @(negedge clk);
    nrst = 1'b1;
    orr[0] = 1'b1;
    @(negedge clk);
    chk("middone_in_ready_high", 128'(ir[0]), 128'(1));
    for (int g = 0; g < NI; g++) begin
      fork
        automatic int gg_i = g;
        run_random(gg_i, 20);
      join_none
    end
    wait fork;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
